bus_arbiter: RTL and testbench

Two-master arbiter that shares the single system memory/MMIO bus (RAM, keyboard, art/display regions) between the CPU load/store port (master 0) and a second bus master such as a DMA engine or boot loader (master 1). It accepts one transaction at a time, selects between simultaneous requests with round-robin priority, and drives the shared bus for exactly one cycle per transaction. It returns a one-cycle `done` pulse, plus read data, to the winning master.

---
 rtl/bus_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-transaction-at-a-time arbiter for the shared
// memory/MMIO bus. Round-robin between simultaneous requests, one bus strobe
// cycle per transaction, one-cycle done pulse with read data to the winner.
//
// Handshake: a master raises req with we/addr/wdata stable; its fields are
// latched when it is granted (IDLE -> ISSUE). The master sees done=1 for
// exactly one cycle, and rdata is valid from that cycle until its next read
// completes. A master must drop req by the cycle after done. A request that
// drops mid-transaction does not cancel it.
module bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [63:0] RAM_BASE     = 64'h0000_0000_0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m0_wdata,
  input  logic [63:0] m1_wdata,
  output logic        m0_done,
  output logic        m1_done,
  output logic [63:0] m0_rdata,
  output logic [63:0] m1_rdata,
  output logic [63:0] bus_address,
  output logic [63:0] bus_write_data,
  output logic        bus_write_enable,
  output logic        bus_read_enable,
  input  logic [63:0] bus_read_data,
  output logic        busy,
  output logic        grant,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        lat_we;
  logic [3:0]  cnt;
  logic        pick;

  assign dbg_state = state;

  // Winner for the next grant: sole requester, or the master that did not win last time.
  always_comb begin
    pick = 1'b0;
    if (m0_req && m1_req) pick = ~last_grant;
    else                  pick = m1_req;
  end

  // Transaction FSM; every output is registered and set on the edge entering its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      last_grant       <= 1'b1;
      grant            <= 1'b1;
      busy             <= 1'b0;
      lat_we           <= 1'b0;
      cnt              <= 4'd0;
      m0_done          <= 1'b0;
      m1_done          <= 1'b0;
      m0_rdata         <= 64'd0;
      m1_rdata         <= 64'd0;
      bus_address      <= RAM_BASE;
      bus_write_data   <= 64'd0;
      bus_write_enable <= 1'b0;
      bus_read_enable  <= 1'b0;
    end else begin
      // Pulses and strobes default low; each state re-asserts what it needs.
      m0_done          <= 1'b0;
      m1_done          <= 1'b0;
      bus_write_enable <= 1'b0;
      bus_read_enable  <= 1'b0;
      bus_write_data   <= 64'd0;
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            state      <= S_ISSUE;
            busy       <= 1'b1;
            grant      <= pick;
            last_grant <= pick;
            lat_we     <= pick ? m1_we : m0_we;
            // The bus address/data registers double as the latched request fields.
            bus_address <= pick ? m1_addr : m0_addr;
            if (pick ? m1_we : m0_we) begin
              bus_write_enable <= 1'b1;
              bus_write_data   <= pick ? m1_wdata : m0_wdata;
            end else begin
              bus_read_enable  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (lat_we) begin
            state       <= S_DONE;
            bus_address <= RAM_BASE;
            if (grant) m1_done <= 1'b1;
            else       m0_done <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= 4'(READ_LATENCY);
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= S_DONE;
            bus_address <= RAM_BASE;
            if (grant) begin
              m1_rdata <= bus_read_data;
              m1_done  <= 1'b1;
            end else begin
              m0_rdata <= bus_read_data;
              m0_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed steps with randomized fields, a memory
// model standing in for the slave, and an expected-read-data queue.
module tb_bus_arbiter;

  localparam logic [63:0] RAM_BASE = 64'h0000_0000_0001_0000;
  localparam logic [63:0] KEY_BASE = 64'h0000_0000_0000_F000;
  localparam logic [63:0] ART_BASE = 64'h0000_0000_0002_0000;
  localparam int LA = 1;
  localparam int LB = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A (READ_LATENCY = 1) ----------------
  logic        a_req[2];
  logic        a_we[2];
  logic [63:0] a_addr[2];
  logic [63:0] a_wdata[2];
  logic        a_done[2];
  logic [63:0] a_rdata[2];
  logic [63:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
  logic        a_bus_we, a_bus_re, a_busy, a_grant;
  logic [1:0]  a_state;

  bus_arbiter #(.READ_LATENCY(LA), .RAM_BASE(RAM_BASE)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_req(a_req[0]), .m1_req(a_req[1]),
    .m0_we(a_we[0]), .m1_we(a_we[1]),
    .m0_addr(a_addr[0]), .m1_addr(a_addr[1]),
    .m0_wdata(a_wdata[0]), .m1_wdata(a_wdata[1]),
    .m0_done(a_done[0]), .m1_done(a_done[1]),
    .m0_rdata(a_rdata[0]), .m1_rdata(a_rdata[1]),
    .bus_address(a_bus_addr), .bus_write_data(a_bus_wdata),
    .bus_write_enable(a_bus_we), .bus_read_enable(a_bus_re),
    .bus_read_data(a_bus_rdata),
    .busy(a_busy), .grant(a_grant), .dbg_state(a_state)
  );

  // ---------------- DUT B (READ_LATENCY = 3) ----------------
  logic        b_req[2];
  logic        b_we[2];
  logic [63:0] b_addr[2];
  logic [63:0] b_wdata[2];
  logic        b_done[2];
  logic [63:0] b_rdata[2];
  logic [63:0] b_bus_addr, b_bus_wdata, b_bus_rdata;
  logic        b_bus_we, b_bus_re, b_busy, b_grant;
  logic [1:0]  b_state;

  bus_arbiter #(.READ_LATENCY(LB), .RAM_BASE(RAM_BASE)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_req(b_req[0]), .m1_req(b_req[1]),
    .m0_we(b_we[0]), .m1_we(b_we[1]),
    .m0_addr(b_addr[0]), .m1_addr(b_addr[1]),
    .m0_wdata(b_wdata[0]), .m1_wdata(b_wdata[1]),
    .m0_done(b_done[0]), .m1_done(b_done[1]),
    .m0_rdata(b_rdata[0]), .m1_rdata(b_rdata[1]),
    .bus_address(b_bus_addr), .bus_write_data(b_bus_wdata),
    .bus_write_enable(b_bus_we), .bus_read_enable(b_bus_re),
    .bus_read_data(b_bus_rdata),
    .busy(b_busy), .grant(b_grant), .dbg_state(b_state)
  );

  // ---------------- memory model / slave ----------------
  logic [63:0] mem[logic [63:0]];

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0], a[63:32]} ^ 64'hC3A5_5A3C_0F0F_F0F0;
  endfunction

  // Slave drives valid data only in the cycle exactly L after the read strobe, junk otherwise.
  int          cyc = 0;
  int          a_rd_cyc = -100;
  int          b_rd_cyc = -100;
  logic [63:0] a_rd_addr = '0;
  logic [63:0] b_rd_addr = '0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (a_bus_re === 1'b1) begin a_rd_cyc = cyc; a_rd_addr = a_bus_addr; end
    if (b_bus_re === 1'b1) begin b_rd_cyc = cyc; b_rd_addr = b_bus_addr; end
    a_bus_rdata = (cyc == a_rd_cyc + LA) ? mem_rd(a_rd_addr) : {$urandom, $urandom};
    b_bus_rdata = (cyc == b_rd_cyc + LB) ? mem_rd(b_rd_addr) : {$urandom, $urandom};
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_rdata[2];
  int          model_last = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, a_busy, 1'b0);
    chk({tag, "_we"}, a_bus_we, 1'b0);
    chk({tag, "_re"}, a_bus_re, 1'b0);
    chk({tag, "_addr"}, a_bus_addr, RAM_BASE);
    chk({tag, "_wdata"}, a_bus_wdata, 64'h0);
    chk({tag, "_done0"}, a_done[0], 1'b0);
    chk({tag, "_done1"}, a_done[1], 1'b0);
    chk({tag, "_rdata0"}, a_rdata[0], exp_rdata[0]);
    chk({tag, "_rdata1"}, a_rdata[1], exp_rdata[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_fields(input int m, input logic we, input logic [63:0] ad, input logic [63:0] wd);
    a_we[m] = we; a_addr[m] = ad; a_wdata[m] = wd; a_req[m] = 1'b1;
  endtask

  function automatic logic [63:0] rand_addr();
    return RAM_BASE + 64'(8 * $urandom_range(0, 7));
  endfunction

  // Called at the negedge of an IDLE cycle with requests already raised.
  // Walks the whole transaction of the expected winner and ends in the next IDLE cycle.
  task automatic serve(input bit raise_other, output int w);
    int          m;
    logic        we;
    logic [63:0] ad, wd;
    m  = (a_req[0] && a_req[1]) ? (1 - model_last) : (a_req[1] ? 1 : 0);
    we = a_we[m]; ad = a_addr[m]; wd = a_wdata[m];
    model_last = m;
    w = m;
    if (we) mem[ad] = wd;
    else    exp_q.push_back(mem_rd(ad));

    @(negedge clk); // ISSUE
    chk("issue_busy", a_busy, 1'b1);
    chk("issue_grant", a_grant, m[0]);
    chk("issue_addr", a_bus_addr, ad);
    chk("issue_we", a_bus_we, we);
    chk("issue_re", a_bus_re, !we);
    chk("issue_wdata", a_bus_wdata, we ? wd : 64'h0);
    chk("issue_done0", a_done[0], 1'b0);
    chk("issue_done1", a_done[1], 1'b0);
    // Fields after grant must be ignored.
    a_addr[m] = {$urandom, $urandom};
    a_wdata[m] = {$urandom, $urandom};
    a_we[m] = ~a_we[m];
    if (raise_other) a_req[1 - m] = 1'b1;

    if (!we) begin
      for (int k = 0; k < LA; k++) begin
        @(negedge clk); // WAIT
        chk("wait_busy", a_busy, 1'b1);
        chk("wait_addr", a_bus_addr, ad);
        chk("wait_re", a_bus_re, 1'b0);
        chk("wait_we", a_bus_we, 1'b0);
        chk("wait_wdata", a_bus_wdata, 64'h0);
        chk("wait_done0", a_done[0], 1'b0);
        chk("wait_done1", a_done[1], 1'b0);
      end
    end

    @(negedge clk); // DONE
    if (!we) exp_rdata[m] = exp_q.pop_front();
    chk("done_winner", a_done[m], 1'b1);
    chk("done_other", a_done[1 - m], 1'b0);
    chk("done_rdata0", a_rdata[0], exp_rdata[0]);
    chk("done_rdata1", a_rdata[1], exp_rdata[1]);
    chk("done_addr", a_bus_addr, RAM_BASE);
    chk("done_we", a_bus_we, 1'b0);
    chk("done_re", a_bus_re, 1'b0);
    chk("done_busy", a_busy, 1'b1);
    a_req[m] = 1'b0;

    @(negedge clk); // IDLE
    check_idle("post");
    chk("post_grant", a_grant, m[0]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n;
    for (int m = 0; m < 2; m++) begin
      a_req[m] = 0; a_we[m] = 0; a_addr[m] = '0; a_wdata[m] = '0;
      b_req[m] = 0; b_we[m] = 0; b_addr[m] = '0; b_wdata[m] = '0;
      exp_rdata[m] = '0;
    end
    mem[KEY_BASE] = 64'h41;

    // Reset values, during and after reset.
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    chk("rst_grant", a_grant, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("rel");
    chk("rel_grant", a_grant, 1'b1);
    chk("rel_b_busy", b_busy, 1'b0);
    chk("rel_b_rdata1", b_rdata[1], 64'h0);

    // Single write: m0 to ART_BASE.
    set_fields(0, 1'b1, ART_BASE, 64'h41);
    serve(1'b0, w);

    // Single read: m1 from KEY_BASE (L=1).
    set_fields(1, 1'b0, KEY_BASE, 64'h0);
    serve(1'b0, w);
    chk("key_rdata_l1", a_rdata[1], 64'h41);

    // Single read with L=3 on the second instance: done lands in cycle 5.
    b_we[1] = 1'b0; b_addr[1] = KEY_BASE; b_req[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b_done[1] !== 1'b1 && n < 20);
    b_req[1] = 1'b0;
    chk("b_latency", 64'(n), 64'd5);
    chk("b_rdata1", b_rdata[1], 64'h41);
    chk("b_done0", b_done[0], 1'b0);
    @(negedge clk);
    chk("b_done1_pulse", b_done[1], 1'b0);
    chk("b_idle_busy", b_busy, 1'b0);

    // Round-robin: both request continuously; winner re-requests immediately.
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++)
        if (!a_req[m]) set_fields(m, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      serve(1'b0, w);
    end
    while (a_req[0] || a_req[1]) serve(1'b0, w);

    // Request during busy: m1 appears during m0's read WAIT.
    set_fields(0, 1'b0, rand_addr(), 64'h0);
    a_we[1] = 1'b0; a_addr[1] = rand_addr(); a_wdata[1] = '0;
    serve(1'b1, w);
    chk("busy_req_pending", a_req[1], 1'b1);
    serve(1'b0, w);

    // Reset mid-read.
    set_fields(0, 1'b0, rand_addr(), 64'h0);
    @(negedge clk); // ISSUE
    @(negedge clk); // WAIT
    reset = 1'b0;
    #1;
    model_last = 1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_q.delete();
    check_idle("mid_rst");
    chk("mid_rst_grant", a_grant, 1'b1);
    a_req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle("after_rst");
    end

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      for (int m = 0; m < 2; m++)
        if (!a_req[m] && $urandom_range(0, 2) != 0)
          set_fields(m, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      if (!a_req[0] && !a_req[1])
        set_fields($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      serve(1'b0, w);
    end
    while (a_req[0] || a_req[1]) serve(1'b0, w);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
